alu_sequencer: RTL and testbench

Parametrised register-file/ALU datapath with its own control FSM, replacing the hand-tied enable and mux selects of the board-level CPU top. It accepts one command per valid/ready handshake, reads operands from an internal register file, executes, writes back and updates a registered flag set. It sits between a future instruction decoder (or test harness) and the seven-segment/debug outputs.

---
 rtl/alu_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_alu_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Register-file/ALU sequencer: one command per 4 cycles (READ, EXEC, WB); cmd_ready only in IDLE, done pulses after writeback.
// Optional shifter (LSH/RSH) is built only when ALU_SHIFT_EN is defined; otherwise those opcodes act as NOP.
module alu_sequencer #(
  parameter int REG_WIDTH     = 16,
  parameter int REG_ADDR_BITS = 3,
  parameter int IMM_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_op,
  input  logic [REG_ADDR_BITS-1:0] cmd_dst,
  input  logic [REG_ADDR_BITS-1:0] cmd_src,
  input  logic [IMM_WIDTH-1:0]     cmd_imm,
  output logic                     done,
  output logic [REG_WIDTH-1:0]     result,
  output logic                     carry_flag,
  output logic                     low_flag,
  output logic                     overflow_flag,
  output logic                     neg_flag,
  output logic                     zero_flag,
  input  logic [REG_ADDR_BITS-1:0] dbg_addr,
  output logic [REG_WIDTH-1:0]     dbg_data
);

  localparam int DEPTH = 2 ** REG_ADDR_BITS;
  localparam int MSB   = REG_WIDTH - 1;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_SUBI = 4'h3;
  localparam logic [3:0] OP_CMP  = 4'h4;
  localparam logic [3:0] OP_CMPI = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_MOV  = 4'h9;
  localparam logic [3:0] OP_MOVI = 4'hA;
`ifdef ALU_SHIFT_EN
  localparam logic [3:0] OP_LSH  = 4'hB;
  localparam logic [3:0] OP_RSH  = 4'hC;
  localparam int         SHW     = $clog2(REG_WIDTH);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [3:0]               op_q;
  logic [REG_ADDR_BITS-1:0] dst_q, src_q;
  logic [IMM_WIDTH-1:0]     imm_q;
  logic [REG_WIDTH-1:0]     a_q, b_q;
  logic [REG_WIDTH-1:0]     result_q, result_d;
  logic                     c_q, l_q, f_q, n_q, z_q;
  logic                     c_d, l_d, f_d, n_d, z_d;
  logic                     we_q, we_d;
  logic                     done_q;
  logic [REG_WIDTH-1:0]     regs_q [DEPTH];

  logic                     use_imm;
  logic [REG_WIDTH-1:0]     imm_sext;
  logic [REG_WIDTH:0]       sum, diff;

  assign use_imm  = (op_q == OP_ADDI) || (op_q == OP_SUBI) ||
                    (op_q == OP_CMPI) || (op_q == OP_MOVI);
  assign imm_sext = REG_WIDTH'($signed(imm_q));
  // Extra top bit of diff is the unsigned borrow (A < B).
  assign sum      = {1'b0, a_q} + {1'b0, b_q};
  assign diff     = {1'b0, a_q} - {1'b0, b_q};

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (cmd_valid) state_d = S_READ;
      S_READ: state_d = S_EXEC;
      S_EXEC: state_d = S_WB;
      S_WB:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    result_d = result_q;
    c_d      = c_q;
    l_d      = l_q;
    f_d      = f_q;
    n_d      = n_q;
    z_d      = z_q;
    we_d     = 1'b0;
    case (op_q)
      OP_ADD, OP_ADDI: begin
        result_d = sum[MSB:0];
        we_d     = 1'b1;
        c_d      = sum[REG_WIDTH];
        f_d      = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
        n_d      = sum[MSB];
        z_d      = (sum[MSB:0] == '0);
      end
      OP_SUB, OP_SUBI: begin
        result_d = diff[MSB:0];
        we_d     = 1'b1;
        c_d      = diff[REG_WIDTH];
        f_d      = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
        n_d      = diff[MSB];
        z_d      = (diff[MSB:0] == '0);
      end
      OP_CMP, OP_CMPI: begin
        result_d = diff[MSB:0];
        l_d      = diff[REG_WIDTH];
        n_d      = $signed(a_q) < $signed(b_q);
        z_d      = (a_q == b_q);
      end
      OP_AND: begin result_d = a_q & b_q; we_d = 1'b1; end
      OP_OR:  begin result_d = a_q | b_q; we_d = 1'b1; end
      OP_XOR: begin result_d = a_q ^ b_q; we_d = 1'b1; end
      OP_MOV, OP_MOVI: begin result_d = b_q; we_d = 1'b1; end
`ifdef ALU_SHIFT_EN
      OP_LSH: begin result_d = a_q << b_q[SHW-1:0]; we_d = 1'b1; end
      OP_RSH: begin result_d = a_q >> b_q[SHW-1:0]; we_d = 1'b1; end
`endif
      default: ;
    endcase
  end

  // Operands are captured in READ, so dst==src sees the pre-write value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q     <= '0;
      dst_q    <= '0;
      src_q    <= '0;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      c_q      <= 1'b0;
      l_q      <= 1'b0;
      f_q      <= 1'b0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (cmd_valid) begin
          op_q  <= cmd_op;
          dst_q <= cmd_dst;
          src_q <= cmd_src;
          imm_q <= cmd_imm;
        end
        S_READ: begin
          a_q <= regs_q[dst_q];
          b_q <= use_imm ? imm_sext : regs_q[src_q];
        end
        S_EXEC: begin
          result_q <= result_d;
          c_q      <= c_d;
          l_q      <= l_d;
          f_q      <= f_d;
          n_q      <= n_d;
          z_q      <= z_d;
          we_q     <= we_d;
        end
        S_WB: begin
          if (we_q) regs_q[dst_q] <= result_q;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready     = (state_q == S_IDLE);
  assign done          = done_q;
  assign result        = result_q;
  assign carry_flag    = c_q;
  assign low_flag      = l_q;
  assign overflow_flag = f_q;
  assign neg_flag      = n_q;
  assign zero_flag     = z_q;
  assign dbg_data      = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: reference model predicts result/flags/register per command.
module tb_alu_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [3:0]   cmd_op;
  logic [2:0]   cmd_dst, cmd_src;
  logic [7:0]   cmd_imm;
  logic         done;
  logic [W-1:0] result;
  logic         carry_flag, low_flag, overflow_flag, neg_flag, zero_flag;
  logic [2:0]   dbg_addr;
  logic [W-1:0] dbg_data;

  alu_sequencer #(.REG_WIDTH(16), .REG_ADDR_BITS(3), .IMM_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_imm(cmd_imm),
    .done(done), .result(result), .carry_flag(carry_flag), .low_flag(low_flag),
    .overflow_flag(overflow_flag), .neg_flag(neg_flag), .zero_flag(zero_flag),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   dst;
    logic [W-1:0] res;
    logic [4:0]   flags;
    logic [W-1:0] rval;
  } exp_t;

  exp_t         sb_q[$];
  logic [W-1:0] m_r [8];
  logic [W-1:0] m_res;
  logic         m_c, m_l, m_f, m_n, m_z;
  int           n_chk = 0;
  int           n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] dut_flags();
    return {carry_flag, low_flag, overflow_flag, neg_flag, zero_flag};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    m_res = '0;
    {m_c, m_l, m_f, m_n, m_z} = 5'b0;
  endfunction

  // Reference model using integer arithmetic for carry/borrow/overflow.
  function automatic exp_t model(input logic [3:0] op, input logic [2:0] dst,
                                 input logic [2:0] src, input logic [7:0] imm);
    exp_t         e;
    logic [W-1:0] a, b, r;
    int           ia, ib, sa, sb, s;
    bit           wr;
    a  = m_r[dst];
    b  = (op == 4'h1 || op == 4'h3 || op == 4'h5 || op == 4'hA) ? {{8{imm[7]}}, imm} : m_r[src];
    ia = int'(a);
    ib = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = m_res;
    wr = 1'b0;
    case (op)
      4'h0, 4'h1: begin
        s = ia + ib; r = W'(s); wr = 1'b1;
        m_c = (s > 65535);
        s = sa + sb; m_f = (s > 32767) || (s < -32768);
        m_n = r[W-1]; m_z = (r == 0);
      end
      4'h2, 4'h3: begin
        s = ia - ib; r = W'(s); wr = 1'b1;
        m_c = (ia < ib);
        s = sa - sb; m_f = (s > 32767) || (s < -32768);
        m_n = r[W-1]; m_z = (r == 0);
      end
      4'h4, 4'h5: begin
        r = W'(ia - ib);
        m_l = (ia < ib); m_n = (sa < sb); m_z = (ia == ib);
      end
      4'h6: begin r = a & b; wr = 1'b1; end
      4'h7: begin r = a | b; wr = 1'b1; end
      4'h8: begin r = a ^ b; wr = 1'b1; end
      4'h9, 4'hA: begin r = b; wr = 1'b1; end
`ifdef ALU_SHIFT_EN
      4'hB: begin r = a << b[3:0]; wr = 1'b1; end
      4'hC: begin r = a >> b[3:0]; wr = 1'b1; end
`endif
      default: ;
    endcase
    m_res = r;
    if (wr) m_r[dst] = r;
    e.dst   = dst;
    e.res   = m_res;
    e.flags = {m_c, m_l, m_f, m_n, m_z};
    e.rval  = m_r[dst];
    return e;
  endfunction

  task automatic pop_and_compare(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_underflow"}, 1, 0);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_result"}, result, e.res);
      check({tag, "_flags"}, dut_flags(), e.flags);
      dbg_addr = e.dst;
      #1;
      check({tag, "_reg"}, dbg_data, e.rval);
    end
  endtask

  // Issues one command, then scrambles the inputs to prove they were latched.
  task automatic do_cmd(input string tag, input logic [3:0] op, input logic [2:0] dst,
                        input logic [2:0] src, input logic [7:0] imm);
    int cycles;
    bit got;
    @(negedge clk);
    check({tag, "_ready"}, cmd_ready, 1);
    check({tag, "_done_low"}, done, 0);
    cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_imm = imm;
    sb_q.push_back(model(op, dst, src, imm));
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op = 4'($urandom); cmd_dst = 3'($urandom); cmd_src = 3'($urandom); cmd_imm = 8'($urandom);
    cycles = 0;
    got = 1'b0;
    while (cycles < 20 && !got) begin
      @(negedge clk);
      cycles++;
      if (done) got = 1'b1;
    end
    check({tag, "_done_seen"}, got, 1);
    if (got) begin
      check({tag, "_latency"}, cycles, 4);
      check({tag, "_ready_with_done"}, cmd_ready, 1);
      pop_and_compare(tag);
    end else begin
      void'(sb_q.pop_front());
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, dn, dcount;
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_dst = '0; cmd_src = '0; cmd_imm = '0;
    dbg_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("rst_ready", cmd_ready, 1);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_flags", dut_flags(), 0);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      check("rst_reg", dbg_data, 0);
    end

    do_cmd("addi1", 4'h1, 3'd1, 3'd0, 8'h7F);
    do_cmd("addi2", 4'h1, 3'd1, 3'd0, 8'h01);
    check("r1_is_0080", dbg_data, 16'h0080);
    check("r1_flags", dut_flags(), 5'b00000);

    do_cmd("movi_r2", 4'hA, 3'd2, 3'd0, 8'hFF);
    check("r2_sext", dbg_data, 16'hFFFF);
    do_cmd("addi_wrap", 4'h1, 3'd2, 3'd0, 8'h01);
    check("wrap_c_z", {carry_flag, zero_flag}, 2'b11);

    do_cmd("movi_r3", 4'hA, 3'd3, 3'd0, 8'h7F);
    do_cmd("movi_r7", 4'hA, 3'd7, 3'd0, 8'h08);
    do_cmd("lsh_r3", 4'hB, 3'd3, 3'd7, 8'h00);
    do_cmd("add_r3r3", 4'h0, 3'd3, 3'd3, 8'h00);

    do_cmd("movi_r4", 4'hA, 3'd4, 3'd0, 8'h01);
    do_cmd("movi_r5", 4'hA, 3'd5, 3'd0, 8'hFF);
    do_cmd("cmp45", 4'h4, 3'd4, 3'd5, 8'h00);
    check("cmp45_lnz", {low_flag, neg_flag, zero_flag}, 3'b100);
    do_cmd("cmp55", 4'h4, 3'd5, 3'd5, 8'h00);
    check("cmp55_lz", {low_flag, zero_flag}, 2'b01);
    do_cmd("sub45", 4'h2, 3'd4, 3'd5, 8'h00);
    check("sub45_val", dbg_data, 16'h0002);
    check("sub45_c", carry_flag, 1);
    do_cmd("nop_e", 4'hE, 3'd4, 3'd5, 8'h00);
    do_cmd("nop_d", 4'hD, 3'd2, 3'd1, 8'h33);
    do_cmd("rsh", 4'hC, 3'd1, 3'd7, 8'h00);
    do_cmd("subi", 4'h3, 3'd6, 3'd0, 8'h80);
    do_cmd("cmpi", 4'h5, 3'd6, 3'd0, 8'h80);
    do_cmd("and", 4'h6, 3'd5, 3'd4, 8'h00);
    do_cmd("or", 4'h7, 3'd5, 3'd3, 8'h00);
    do_cmd("xor", 4'h8, 3'd5, 3'd1, 8'h00);
    do_cmd("mov", 4'h9, 3'd0, 3'd5, 8'h00);

    for (int i = 0; i < 24; i++)
      do_cmd("rnd", 4'($urandom), 3'($urandom), 3'($urandom), 8'($urandom));

    // cmd_valid held high across 12 edges: exactly three acceptances.
    do_cmd("clr_r7", 4'hA, 3'd7, 3'd0, 8'h00);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'h1; cmd_dst = 3'd7; cmd_src = 3'd0; cmd_imm = 8'h01;
    acc = 0;
    dn = 0;
    for (int i = 0; i <= 12; i++) begin
      if (done) begin
        dn++;
        check("b2b_result", result, 16'(dn));
        if (sb_q.size() != 0) void'(sb_q.pop_front());
      end
      if (i == 12) cmd_valid = 1'b0;
      else if (cmd_ready) begin
        sb_q.push_back(model(4'h1, 3'd7, 3'd0, 8'h01));
        acc++;
      end
      if (i < 12) @(negedge clk);
    end
    check("b2b_accepts", acc, 3);
    check("b2b_dones", dn, 3);
    check("b2b_sb_empty", sb_q.size(), 0);
    dbg_addr = 3'd7;
    #1;
    check("b2b_r7", dbg_data, 16'd3);

    // Make flags/result non-zero, then abort ADDI R6 in EXEC with reset.
    do_cmd("pre_rst", 4'h2, 3'd4, 3'd2, 8'h00);
    do_cmd("pre_rst_cmp", 4'h4, 3'd6, 3'd6, 8'h00);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'h1; cmd_dst = 3'd6; cmd_src = 3'd0; cmd_imm = 8'h05;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    check("abort_done", done, 0);
    check("abort_ready", cmd_ready, 1);
    check("abort_result", result, 0);
    check("abort_flags", dut_flags(), 0);
    dbg_addr = 3'd6;
    #1;
    check("abort_r6", dbg_data, 0);
    dbg_addr = 3'd4;
    #1;
    check("abort_r4", dbg_data, 0);
    dcount = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("abort_no_done", dcount, 0);
    do_cmd("post_rst", 4'h1, 3'd6, 3'd0, 8'h05);
    check("post_rst_r6", dbg_data, 16'd5);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
